spi_ram_cmd_decoder: RTL and testbench
======================================

Name: spi_ram_cmd_decoder

Overview:
- Single-port synchronous RAM with a command decoder, directly downstream of the SPI slave.
- Consumes each 10-bit frame the slave delivers (rx_data/rx_valid) and decodes the 2-bit opcode in bits [9:8].
- Updates the write/read address registers or the memory.
- Returns read data to the slave on dout/tx_valid for serialisation onto MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words in the array; legal range 2..2**ADDR_SIZE.
- ADDR_SIZE, 8, width of the address registers and of the address field in din[7:0].

Ports:
- clk  input  1  rising-edge clock, shared with the SPI slave.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  10  frame from the SPI slave: [9:8] opcode, [7:0] payload.
- rx_valid  input  1  din is valid this cycle; one-cycle pulse per frame.
- dout  output  8  read data toward the SPI slave.
- tx_valid  output  1  dout is valid; level signal.
- err  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (async, rst_n=0) clears wr_addr, rd_addr, dout, tx_valid, err, wr_addr_set and rd_addr_set to 0. The memory array is NOT cleared.
- A reset asserted mid-sequence discards any pending address. After reset, the first data operation requires a fresh address command.
- Frames are decoded only on a rising clk with rx_valid=1. With rx_valid=0, all state holds (dout, tx_valid, addresses).
- Opcode 00, write address: wr_addr <= din[7:0]; wr_addr_set <= 1.
- Opcode 01, write data: mem[wr_addr] <= din[7:0]. The write lands at the same edge, so a read of that location in a later frame sees the new value.
- Opcode 10, read address: rd_addr <= din[7:0]; rd_addr_set <= 1.
- Opcode 11, read data: dout <= mem[rd_addr]; tx_valid <= 1 at that same edge, i.e. 1-cycle latency from the rx_valid edge. payload din[7:0] is ignored (dummy byte).
- tx_valid rule: on every accepted frame, tx_valid <= (opcode==11). Otherwise it holds its value, so it stays high until the next frame is accepted. dout holds its last value when tx_valid falls.
- Address range: an address >= MEM_DEPTH is captured as-is.
  - A write with out-of-range wr_addr is dropped and sets err.
  - A read with out-of-range rd_addr returns dout=8'h00, still asserts tx_valid, and sets err.
- Sequencing errors set err:
  - opcode 01 with wr_addr_set=0: the write is still performed at wr_addr.
  - opcode 11 with rd_addr_set=0: the read is still performed.
- err is sticky until reset.
- Consecutive rx_valid pulses, including back-to-back cycles, are each fully processed. No back-pressure exists; the block never stalls.
- There is a single read and a single write port into the array, and one frame is handled per cycle, so there is no read/write collision.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- When defined:
  - After each opcode 01, wr_addr <= wr_addr+1.
  - After each opcode 11, rd_addr <= rd_addr+1.
  - Increment wraps from MEM_DEPTH-1 to 0.
  - An out-of-range address does not increment.
- When undefined: addresses change only on opcodes 00/10, and repeated data frames hit the same location.

Test Plan:
- Reset, then frames 0x0_12 (wr addr 0x12), 0x1_A5, 0x2_12, 0x3_00 -> one cycle after the last rx_valid: tx_valid=1, dout=0xA5, err=0.
- Back-to-back rx_valid on consecutive cycles: 0x0_03, 0x1_3C, 0x2_03, 0x3_FF -> dout=0x3C, tx_valid=1. The next frame 0x0_04 drops tx_valid to 0 while dout stays 0x3C.
- After reset, send 0x1_77 with no prior write address -> err=1 and mem[0]=0x77. err stays 1 through later legal frames until rst_n pulses low.
- MEM_DEPTH=128: frame 0x0_80 then 0x1_55 -> write dropped, err=1. Frame 0x2_80 then 0x3_00 -> dout=0x00, tx_valid=1.
- Assert rst_n low mid-sequence, after 0x2_10 and before 0x3_00 -> tx_valid=0, dout=0x00, rd_addr=0. The following 0x3_00 then flags err=1.
- With SPI_RAM_AUTOINC_EN: 0x0_FE, 0x1_11, 0x1_22, 0x1_33 (MEM_DEPTH=256) -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap). Read back likewise via 0x2_FE followed by three 0x3_00 frames -> 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/spi_ram_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_ram_cmd_decoder
//   Single-port synchronous RAM with a command decoder that sits directly
//   behind the SPI slave. Each 10-bit frame carries a 2-bit opcode in [9:8]:
//     00 write address, 01 write data, 10 read address, 11 read data.
//   Read data is returned on dout/tx_valid with one cycle of latency.
//
// Ports
//   clk       rising-edge clock shared with the SPI slave
//   rst_n     asynchronous active-low reset
//   din       frame from the slave: [9:8] opcode, [7:0] payload
//   rx_valid  one-cycle pulse marking a valid frame on din
//   dout      read data toward the slave
//   tx_valid  dout valid; level, updated only when a frame is accepted
//   err       sticky protocol / address-range error flag
//
// Parameters
//   MEM_DEPTH  number of 8-bit words (2 .. 2**ADDR_SIZE)
//   ADDR_SIZE  width of the address registers and of the address field
//
// Build option
//   SPI_RAM_AUTOINC_EN  when defined, each write-data frame advances wr_addr
//                       and each read-data frame advances rd_addr, wrapping
//                       from MEM_DEPTH-1 to 0; out-of-range addresses hold.
// -----------------------------------------------------------------------------
module spi_ram_cmd_decoder #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  logic [7:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_addr_set_q, wr_addr_set_d;
  logic                 rd_addr_set_q, rd_addr_set_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;

  opcode_e op;
  logic    wr_in_range;
  logic    rd_in_range;

  assign op = opcode_e'(din[9:8]);

  // Addresses are captured at full width; only in-range ones touch the array.
  assign wr_in_range = (32'(wr_addr_q) < DEPTH_U);
  assign rd_in_range = (32'(rd_addr_q) < DEPTH_U);

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) == DEPTH_U - 32'd1) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_set_d = wr_addr_set_q;
    rd_addr_set_d = rd_addr_set_q;
    dout_d        = dout_q;
    tx_valid_d    = tx_valid_q;
    err_d         = err_q;
    mem_we        = 1'b0;

    if (rx_valid) begin
      // tx_valid tracks the opcode of the most recently accepted frame.
      tx_valid_d = (op == OP_RD_DATA);
      unique case (op)
        OP_WR_ADDR: begin
          wr_addr_d     = din[ADDR_SIZE-1:0];
          wr_addr_set_d = 1'b1;
        end
        OP_WR_DATA: begin
          // A write without a prior address still lands at wr_addr.
          if (!wr_addr_set_q) err_d = 1'b1;
          if (wr_in_range) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d     = din[ADDR_SIZE-1:0];
          rd_addr_set_d = 1'b1;
        end
        OP_RD_DATA: begin
          if (!rd_addr_set_q) err_d = 1'b1;
          if (rd_in_range) begin
            dout_d = mem[rd_addr_q[IDX_W-1:0]];
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = next_addr(rd_addr_q);
`endif
          end else begin
            dout_d = 8'h00;
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_set_q <= 1'b0;
      rd_addr_set_q <= 1'b0;
      dout_q        <= 8'h00;
      tx_valid_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_set_q <= wr_addr_set_d;
      rd_addr_set_q <= rd_addr_set_d;
      dout_q        <= dout_d;
      tx_valid_q    <= tx_valid_d;
      err_q         <= err_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and it maps onto a
  // plain RAM macro.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q[IDX_W-1:0]] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_cmd_decoder
//   Scoreboard bench for spi_ram_cmd_decoder (MEM_DEPTH=128 so both the
//   in-range and out-of-range address paths are reachable). The driver feeds
//   frames into a reference model that pushes the expected outputs into a
//   queue; a monitor pops one entry per accepted frame and compares, and on
//   idle cycles checks that the outputs hold.
// -----------------------------------------------------------------------------
module tb_spi_ram_cmd_decoder;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  always #5 clk = ~clk;

  spi_ram_cmd_decoder #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       tv;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t sb_q[$];

  int  m_wa, m_ra;
  bit  m_wset, m_rset, m_err, m_tv;
  int  m_dout;
  int  m_mem [256];

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wset = 0; m_rset = 0;
    m_err = 0; m_tv = 0; m_dout = 0;
  endtask

  task automatic model_frame(input logic [9:0] f);
    int op, p;
    op = int'(f[9:8]);
    p  = int'(f[7:0]);
    case (op)
      0: begin m_wa = p; m_wset = 1; end
      1: begin
        if (!m_wset) m_err = 1;
        if (m_wa < DEPTH) begin
          m_mem[m_wa] = p;
`ifdef SPI_RAM_AUTOINC_EN
          m_wa = (m_wa + 1) % DEPTH;
`endif
        end else m_err = 1;
      end
      2: begin m_ra = p; m_rset = 1; end
      default: begin
        if (!m_rset) m_err = 1;
        if (m_ra < DEPTH) begin
          m_dout = m_mem[m_ra];
`ifdef SPI_RAM_AUTOINC_EN
          m_ra = (m_ra + 1) % DEPTH;
`endif
        end else begin
          m_dout = 0;
          m_err  = 1;
        end
      end
    endcase
    m_tv = (op == 3);
    sb_q.push_back('{tv: m_tv, d: 8'(m_dout), e: m_err});
  endtask

  // ---------------- monitor ----------------
  exp_t last_exp = '0;
  logic mon_acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      last_exp = '0;
    end else begin
      mon_acc = rx_valid;
      #1;
      if (mon_acc) begin
        check("frame_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) last_exp = sb_q.pop_front();
      end
      check("mon_tx_valid", 32'(tx_valid), 32'(last_exp.tv));
      check("mon_dout",     32'(dout),     32'(last_exp.d));
      check("mon_err",      32'(err),      32'(last_exp.e));
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic frame(input logic [9:0] f);
    din      = f;
    rx_valid = 1'b1;
    model_frame(f);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    check("drained_before_reset", 32'(sb_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_dout",     32'(dout),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] rd_seen [3];
  logic [7:0] ai_exp  [3];

  initial begin
    rst_n    = 1'b0;
    din      = '0;
    rx_valid = 1'b0;
    model_reset();
    #1;
    check("por_tx_valid", 32'(tx_valid), 32'd0);
    check("por_dout",     32'(dout),     32'd0);
    check("por_err",      32'(err),      32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Write data with no prior address: still lands at address 0, flags err.
    frame(10'h1_77);
    check("noaddr_err", 32'(err), 32'd1);
    idle(1);
    frame(10'h2_00);
    frame(10'h3_00);
    check("noaddr_mem0", 32'(dout), 32'h77);
    check("err_sticky",  32'(err),  32'd1);
    idle(2);
    do_reset();

    // Fill the whole array so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      frame({2'b00, 8'(i)});
      frame({2'b01, 8'($urandom_range(255))});
    end
    idle(1);

    // Basic write then read back with gaps.
    frame(10'h0_12); idle(1);
    frame(10'h1_A5); idle(2);
    frame(10'h2_12); idle(1);
    frame(10'h3_00);
    check("tp1_tx_valid", 32'(tx_valid), 32'd1);
    check("tp1_dout",     32'(dout),     32'hA5);
    check("tp1_err",      32'(err),      32'd0);
    idle(3);

    // Back-to-back frames, then an address frame drops tx_valid.
    frame(10'h0_03);
    frame(10'h1_3C);
    frame(10'h2_03);
    frame(10'h3_FF);
    check("b2b_tx_valid", 32'(tx_valid), 32'd1);
    check("b2b_dout",     32'(dout),     32'h3C);
    frame(10'h0_04);
    check("drop_tx_valid", 32'(tx_valid), 32'd0);
    check("drop_dout",     32'(dout),     32'h3C);
    idle(2);

    // Out-of-range write is dropped, out-of-range read returns zero.
    frame(10'h0_80);
    frame(10'h1_55);
    check("oor_wr_err", 32'(err), 32'd1);
    frame(10'h2_80);
    frame(10'h3_00);
    check("oor_rd_dout",     32'(dout),     32'h00);
    check("oor_rd_tx_valid", 32'(tx_valid), 32'd1);
    idle(1);

    // Reset between read-address and read-data frames discards the address.
    do_reset();
    frame(10'h2_10);
    do_reset();
    frame(10'h3_00);
    check("rst_mid_err", 32'(err), 32'd1);
    idle(1);

    // Consecutive data frames near the top of the array.
    do_reset();
    frame(10'h0_7E);
    frame(10'h1_11);
    frame(10'h1_22);
    frame(10'h1_33);
    frame(10'h2_7E);
    for (int i = 0; i < 3; i++) begin
      frame(10'h3_00);
      rd_seen[i] = dout;
    end
`ifdef SPI_RAM_AUTOINC_EN
    ai_exp[0] = 8'h11; ai_exp[1] = 8'h22; ai_exp[2] = 8'h33;
`else
    ai_exp[0] = 8'h33; ai_exp[1] = 8'h33; ai_exp[2] = 8'h33;
`endif
    for (int i = 0; i < 3; i++) check("burst_read", 32'(rd_seen[i]), 32'(ai_exp[i]));
    check("burst_err", 32'(err), 32'd0);
    idle(1);

    // Randomised traffic, including out-of-range addresses and resets.
    for (int n = 0; n < 600; n++) begin
      logic [1:0] op;
      logic [7:0] p;
      op = 2'($urandom_range(3));
      if (op == 2'b00 || op == 2'b10)
        p = ($urandom_range(7) == 0) ? 8'($urandom_range(255, DEPTH)) : 8'($urandom_range(DEPTH - 1));
      else
        p = 8'($urandom_range(255));
      frame({op, p});
      if ($urandom_range(3) == 0) idle($urandom_range(2));
      if (n % 200 == 199) do_reset();
    end

    // Bounded drain of anything still pending.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("final_drained", 32'(sb_q.size()), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
